// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller
//
// Issues sequential instruction-memory reads from a fetch PC and buffers the
// returned words, each paired with the PC of its request, in a 2-entry FIFO
// that feeds decode. No more than one memory request is outstanding at a
// time. A redirect flushes the FIFO and reloads the fetch PC. If a request is
// still in flight when the redirect arrives, its response is discarded later
// in the DRAIN state.
//
// Configuration macro:
//   FETCH_CTRL_BYPASS_EN : when defined, a response that arrives while the
//                          FIFO is empty is shown on inst_o/inst_pc_o in the
//                          same cycle. When undefined, every response goes
//                          through the FIFO and the decode-side outputs come
//                          straight from registers.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   redirect_i     redirect strobe (branch/jump/trap)
//   redirect_pc_i  redirect target; bits [1:0] are ignored
//   im_req_o       instruction-memory read request
//   im_addr_o      request address
//   im_gnt_i       request accepted when im_req_o && im_gnt_i
//   im_rvalid_i    read data valid, in order
//   im_dout_i      read data
//   inst_valid_o   instruction available to decode
//   inst_o         instruction word
//   inst_pc_o      address of inst_o
//   inst_ready_i   decode accepts when inst_valid_o && inst_ready_i
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_gnt_i,
  input  logic        im_rvalid_i,
  input  logic [31:0] im_dout_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_r;
  state_e      state_s;

  logic [31:0] pc_r;          // next address to request
  logic [31:0] req_pc_r;      // address of the request in flight
  logic        out_r;         // one request granted, response pending

  // FIFO held as a 2-deep shift register: entry 0 is always the head
  logic [1:0]  count_r;
  logic [1:0]  count_s;
  logic [1:0]  count_pop_s;
  logic        valid_r;
  logic [31:0] e0_inst_r;
  logic [31:0] e0_pc_r;
  logic [31:0] e1_inst_r;
  logic [31:0] e1_pc_r;
  logic [31:0] e0_inst_s;
  logic [31:0] e0_pc_s;
  logic [31:0] e1_inst_s;
  logic [31:0] e1_pc_s;

  logic        pop_s;
  logic        fifo_pop_s;
  logic        push_s;
  logic        rsp_s;
  logic        rsp_live_s;
  logic        byp_s;
  logic        grant_s;
  logic        req_s;
  logic [2:0]  free_s;

  // A response only counts when a request is actually in flight, so stray
  // rvalid pulses left over from before a reset are ignored.
  assign rsp_s      = im_rvalid_i & out_r;
  // Responses are kept only in RUN and only if no redirect happens this cycle.
  assign rsp_live_s = rsp_s & (state_r == ST_RUN) & ~redirect_i;

`ifdef FETCH_CTRL_BYPASS_EN
  // Empty FIFO: forward the live response directly to decode
  assign byp_s        = rsp_live_s & (count_r == 2'd0);
  assign inst_valid_o = valid_r | byp_s;
  assign inst_o       = byp_s ? im_dout_i : e0_inst_r;
  assign inst_pc_o    = byp_s ? req_pc_r  : e0_pc_r;
`else
  assign byp_s        = 1'b0;
  assign inst_valid_o = valid_r;
  assign inst_o       = e0_inst_r;
  assign inst_pc_o    = e0_pc_r;
`endif

  assign pop_s      = inst_valid_o & inst_ready_i;
  // Only pop the FIFO if it actually held the head. A bypassed word is
  // consumed without ever being stored.
  assign fifo_pop_s = pop_s & valid_r;
  assign push_s     = rsp_live_s & ~(byp_s & pop_s);

  // Slots left after counting stored words and the response still in flight.
  // count + outstanding never exceeds 2, so the value cannot go below zero.
  assign free_s  = 3'd2 + {2'd0, pop_s} - {1'b0, count_r} - {2'd0, out_r};
  assign grant_s = req_s & im_gnt_i;

  assign im_req_o  = req_s;
  assign im_addr_o = pc_r;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        // The in-flight response would carry a stale PC, so wait for it
        if (redirect_i && out_r && !im_rvalid_i) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // A redirect here only retargets the PC; leave once the response lands
        if (rsp_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_BOOT;
      end
    endcase
  end

  // Output logic: memory request qualification
  always_comb begin
    req_s = 1'b0;
    if ((state_r == ST_RUN) && !redirect_i && (free_s != 3'd0) &&
        (!out_r || im_rvalid_i)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Fetch PC, request-in-flight tracking and PC of the request in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r     <= RESET_PC;
      req_pc_r <= 32'h0000_0000;
      out_r    <= 1'b0;
    end else begin
      if (redirect_i) begin
        pc_r <= {redirect_pc_i[31:2], 2'b00};
      end else if (grant_s) begin
        pc_r <= pc_r + 32'd4;
      end else begin
        pc_r <= pc_r;
      end

      if (grant_s) begin
        req_pc_r <= pc_r;
        out_r    <= 1'b1;
      end else if (rsp_s) begin
        req_pc_r <= req_pc_r;
        out_r    <= 1'b0;
      end else begin
        req_pc_r <= req_pc_r;
        out_r    <= out_r;
      end
    end
  end

  // FIFO next-state: apply the pop first, then the push, and let a redirect
  // flush everything
  always_comb begin
    count_pop_s = count_r - {1'b0, fifo_pop_s};
    count_s     = count_r;
    e0_inst_s   = e0_inst_r;
    e0_pc_s     = e0_pc_r;
    e1_inst_s   = e1_inst_r;
    e1_pc_s     = e1_pc_r;
    if (redirect_i) begin
      count_s = 2'd0;
    end else begin
      if (fifo_pop_s) begin
        e0_inst_s = e1_inst_r;
        e0_pc_s   = e1_pc_r;
      end else begin
        e0_inst_s = e0_inst_r;
        e0_pc_s   = e0_pc_r;
      end
      if (push_s) begin
        if (count_pop_s == 2'd0) begin
          e0_inst_s = im_dout_i;
          e0_pc_s   = req_pc_r;
        end else begin
          e1_inst_s = im_dout_i;
          e1_pc_s   = req_pc_r;
        end
        count_s = count_pop_s + 2'd1;
      end else begin
        count_s = count_pop_s;
      end
    end
  end

  // FIFO storage and registered valid flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r   <= 2'd0;
      valid_r   <= 1'b0;
      e0_inst_r <= 32'h0000_0000;
      e0_pc_r   <= 32'h0000_0000;
      e1_inst_r <= 32'h0000_0000;
      e1_pc_r   <= 32'h0000_0000;
    end else begin
      count_r   <= count_s;
      valid_r   <= (count_s != 2'd0);
      e0_inst_r <= e0_inst_s;
      e0_pc_r   <= e0_pc_s;
      e1_inst_r <= e1_inst_s;
      e1_pc_r   <= e1_pc_s;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl
//
// The bench contains a memory responder and a queue-based reference model of
// the fetch behaviour. Each cycle, inputs are driven on the falling edge and
// the outputs are compared 1 ns later. Directed phases are followed by a long
// randomized phase that includes resets and redirects.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef FETCH_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_gnt_i = 1'b0;
  logic        im_rvalid_i = 1'b0;
  logic [31:0] im_dout_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .im_req_o     (im_req_o),
    .im_addr_o    (im_addr_o),
    .im_gnt_i     (im_gnt_i),
    .im_rvalid_i  (im_rvalid_i),
    .im_dout_i    (im_dout_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: dut=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Memory contents: a simple address-dependent pattern
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Reference model state
  logic [31:0] m_q_inst[$];
  logic [31:0] m_q_pc[$];
  logic [31:0] m_out[$];      // PCs of requests in flight (0 or 1 entry)
  logic [31:0] m_pc;
  bit          m_init  = 1'b0;
  bit          m_boot  = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_fresh = 1'b0;

  // Memory responder state
  bit          e_pend = 1'b0;
  int          e_cnt  = 0;
  logic [31:0] e_addr = 32'h0;

  bit          log_en = 1'b0;
  logic [31:0] dlog[$];

  // rmode: 0 none, 1 always, 2 when a request is in flight and rvalid is low,
  //        3 when rvalid and a pop coincide at one stored word, 4 random
  task automatic do_cycle(input bit rst, input int rmode, input logic [31:0] tgt,
                          input int gnt_pct, input int dmin, input int dmax,
                          input int rdy_pct, output bit fired);
    bit          rv, redir, rdy, rsp, live, exp_valid, pop, exp_req, grant, byp_taken;
    int          free;
    logic [31:0] rdata, gaddr, exp_inst, exp_ipc;
    @(negedge clk);
    rv    = e_pend && (e_cnt == 0);
    rdata = rv ? mem_word(e_addr) : $urandom();
    rdy   = ($urandom_range(99) < rdy_pct);
    case (rmode)
      1:       redir = 1'b1;
      2:       redir = (m_out.size() != 0) && !rv;
      3:       redir = (m_q_pc.size() == 1) && rv && (m_out.size() != 0) && rdy && !m_drain;
      4:       redir = ($urandom_range(99) < 8);
      default: redir = 1'b0;
    endcase
    fired         = redir;
    rst_i         = rst;
    im_rvalid_i   = rv;
    im_dout_i     = rdata;
    im_gnt_i      = (!e_pend || rv) && ($urandom_range(99) < gnt_pct);
    inst_ready_i  = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    #1;
    rsp       = rv && (m_out.size() != 0);
    live      = rsp && !m_drain && !redir && !m_boot;
    exp_valid = (m_q_pc.size() != 0) || (BYP && live);
    pop       = exp_valid && rdy;
    free      = 2 - m_q_pc.size() - m_out.size() + (pop ? 1 : 0);
    exp_req   = !m_boot && !m_drain && !redir && (free > 0) && ((m_out.size() == 0) || rv);
    if (m_init) begin
      check_eq("im_req", 32'(im_req_o), 32'(exp_req));
      if (exp_req || m_fresh) check_eq("im_addr", im_addr_o, m_pc);
      check_eq("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        exp_inst = (m_q_pc.size() != 0) ? m_q_inst[0] : rdata;
        exp_ipc  = (m_q_pc.size() != 0) ? m_q_pc[0] : m_out[0];
        check_eq("inst", inst_o, exp_inst);
        check_eq("inst_pc", inst_pc_o, exp_ipc);
      end
      if (m_fresh) begin
        check_eq("rst_inst", inst_o, 32'h0);
        check_eq("rst_inst_pc", inst_pc_o, 32'h0);
      end
      if (log_en && inst_valid_o && rdy) dlog.push_back(inst_pc_o);
    end
    grant = exp_req && im_gnt_i;
    gaddr = m_pc;
    // reference model update for this clock edge
    m_fresh = 1'b0;
    if (rst) begin
      m_init = 1'b1; m_boot = 1'b1; m_drain = 1'b0; m_fresh = 1'b1; m_pc = RPC;
      m_q_inst.delete(); m_q_pc.delete(); m_out.delete();
    end else if (m_init) begin
      byp_taken = BYP && (m_q_pc.size() == 0) && live && pop;
      if (redir) begin
        m_q_inst.delete(); m_q_pc.delete();
        m_pc = {tgt[31:2], 2'b00};
        if (rsp) begin
          m_out.delete(); m_drain = 1'b0;
        end else if (m_out.size() != 0) begin
          m_drain = 1'b1;
        end
      end else begin
        if (pop && (m_q_pc.size() != 0)) begin
          void'(m_q_inst.pop_front()); void'(m_q_pc.pop_front());
        end
        if (live && !byp_taken) begin
          m_q_inst.push_back(rdata); m_q_pc.push_back(m_out[0]);
        end
        if (rsp) begin
          m_out.delete(); m_drain = 1'b0;
        end
        if (grant) begin
          m_out.push_back(m_pc); m_pc = m_pc + 32'd4;
        end
      end
      m_boot = 1'b0;
    end
    // memory responder update (it keeps running across reset)
    if (rv) e_pend = 1'b0;
    else if (e_pend) e_cnt--;
    if (im_gnt_i && im_req_o) begin
      e_pend = 1'b1;
      e_cnt  = $urandom_range(dmax, dmin) - 1;
      e_addr = im_addr_o;
    end
  endtask

  logic [31:0] tgts[4];

  initial begin
    bit f;
    bit got;
    tgts[0] = 32'h0000_2003;
    tgts[1] = 32'hFFFF_FFF8;
    tgts[2] = 32'hFFFF_FFFE;
    tgts[3] = 32'h0000_0000;

    // Reset release, streaming: first request in cycle 2 at RESET_PC
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 0, 32'h0, 100, 1, 1, 100, f);
    log_en = 1'b1;
    do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 100, f);
    check_eq("boot_req", 32'(im_req_o), 32'h0);
    do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 100, f);
    check_eq("first_req", 32'(im_req_o), 32'h1);
    check_eq("first_addr", im_addr_o, 32'h0000_0100);
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 100, f);
    log_en = 1'b0;
    check_eq("a_count", 32'(dlog.size() >= 3), 32'h1);
    if (dlog.size() >= 3) begin
      check_eq("a_pc0", dlog[0], 32'h0000_0100);
      check_eq("a_pc1", dlog[1], 32'h0000_0104);
      check_eq("a_pc2", dlog[2], 32'h0000_0108);
    end

    // Decode stalled: FIFO fills, requests stop, then the stream resumes
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 0, f);
    check_eq("stall_req", 32'(im_req_o), 32'h0);
    check_eq("stall_valid", 32'(inst_valid_o), 32'h1);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 100, f);

    // Redirect to 0x2003 while a slow response is in flight
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      do_cycle(1'b0, 2, 32'h0000_2003, 100, 3, 3, 100, f);
      got = f;
    end
    check_eq("drain_trig", 32'(got), 32'h1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      do_cycle(1'b0, 0, 32'h0, 100, 3, 3, 100, f);
      got = im_req_o;
    end
    check_eq("drain_req", 32'(im_req_o), 32'h1);
    check_eq("drain_addr", im_addr_o, 32'h0000_2000);

    // Redirect coinciding with rvalid and a pop at one stored word
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 100, f);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      do_cycle(1'b0, 3, 32'h0000_3000, 100, 1, 1, 100, f);
      got = f;
    end
    check_eq("coin_trig", 32'(got), 32'h1);
    do_cycle(1'b0, 0, 32'h0, 100, 1, 1, 100, f);
    check_eq("coin_valid", 32'(inst_valid_o), 32'h0);
    check_eq("coin_addr", im_addr_o, 32'h0000_3000);

    // PC wrap at the top of the address space
    do_cycle(1'b0, 1, 32'hFFFF_FFF4, 100, 1, 1, 100, f);
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 0, 32'h0, 100, 1, 2, 100, f);

    // Randomized traffic with resets and redirects
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(99) < 1), 4,
               ($urandom_range(3) == 3) ? $urandom() : tgts[$urandom_range(2)],
               70, 1, 4, 70, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Port clk_i  in  1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_i  in  1: reset, SHALL be synchronous and active-high.
REQ-004 Port redirect_i  in  1: branch/jump/trap redirect strobe.
REQ-005 Port redirect_pc_i  in  32: redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-006 Port im_req_o  out  1: instruction-memory read request.
REQ-007 Port im_addr_o  out  32: request address, valid while im_req_o=1.
REQ-008 Port im_gnt_i  in  1: request accepted when im_req_o && im_gnt_i.
REQ-009 Port im_rvalid_i  in  1: read data valid, in order, at least 1 cycle after grant.
REQ-010 Port im_dout_i  in  32: read data, sampled only when im_rvalid_i=1.
REQ-011 Port inst_valid_o  out  1: instruction available to decode.
REQ-012 Port inst_o  out  32: instruction word.
REQ-013 Port inst_pc_o  out  32: address of inst_o.
REQ-014 Port inst_ready_i  in  1: decode accepts; transfer when inst_valid_o && inst_ready_i.

Function
REQ-015 State machine SHALL have states BOOT, RUN, DRAIN; reset enters BOOT.
REQ-016 BOOT SHALL last exactly 1 cycle with im_req_o=0, then go to RUN.
REQ-017 Internal 2-entry FIFO SHALL hold {inst, pc} pairs; inst_o/inst_pc_o SHALL show the head entry, inst_valid_o = (count != 0).
REQ-018 At most one memory request SHALL be outstanding (granted, no rvalid yet).
REQ-019 free = 2 - count - outstanding + pop, where pop = inst_valid_o && inst_ready_i.
REQ-020 im_req_o SHALL be 1 only in RUN, redirect_i=0, free>0, and (no outstanding or im_rvalid_i=1 this cycle).
REQ-021 im_req_o SHALL stay high with a stable im_addr_o until granted, unless a redirect occurs.
REQ-022 On grant, fetch PC SHALL advance by 4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0).
REQ-023 Each accepted response SHALL be pushed with the PC of its request; a push and a pop in the same cycle SHALL be legal at any count.
REQ-024 On redirect_i=1:
- FIFO flushed.
- Fetch PC <= {redirect_pc_i[31:2],2'b00}.
- im_req_o=0 that cycle.
REQ-025 Redirect with a request outstanding and im_rvalid_i=0 SHALL enter DRAIN.
REQ-026 DRAIN SHALL:
- hold im_req_o=0;
- discard the next response;
- return to RUN the cycle after that response.
REQ-027 Redirect with im_rvalid_i=1 in the same cycle SHALL discard that response and stay in RUN.
REQ-028 Redirect in DRAIN SHALL update the target PC and remain in DRAIN.
REQ-029 Redirect wins over a same-cycle push or pop: the FIFO SHALL be empty next cycle.
REQ-030 The FIFO SHALL never overflow; a push when full is a design error (bench assertion).

Reset
REQ-031 On rst_i=1 at a clock edge:
- state=BOOT, fetch PC=RESET_PC, FIFO count=0, outstanding=0.
- im_req_o=0, im_addr_o=RESET_PC.
- inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-032 Reset mid-operation SHALL abandon any outstanding request; responses arriving after reset SHALL be ignored.

Configuration
REQ-033 Macro FETCH_CTRL_BYPASS_EN, when defined, SHALL present a response directly on inst_o/inst_pc_o with inst_valid_o=1 in the same cycle when the FIFO is empty.
- If popped that cycle, the response SHALL NOT be pushed.
REQ-034 Without FETCH_CTRL_BYPASS_EN, every response SHALL be pushed, giving 1-cycle response-to-inst_valid_o latency; outputs SHALL be register-driven only.

Verification
REQ-035 Reset release, RESET_PC=0x100, gnt always 1, rvalid 1 cycle after grant, ready=1 -> first im_req_o in cycle 2 (addr 0x100); then addresses 0x100, 0x104, 0x108 delivered in order.
REQ-036 inst_ready_i=0 for 10 cycles -> count reaches 2, im_req_o drops, no data lost; on ready=1, words resume in PC order.
REQ-037 Redirect to 0x2003 while one request is outstanding with rvalid delayed 3 cycles -> DRAIN; stale word never appears; next im_addr_o=0x2000.
REQ-038 Redirect coincident with rvalid and pop at count=1 -> inst_valid_o=0 next cycle; next request to the target.
REQ-039 Fetch PC 0xFFFF_FFFC granted -> next im_addr_o=0x0000_0000.
REQ-040 With FETCH_CTRL_BYPASS_EN: empty FIFO and rvalid with data 0x00000013 -> inst_valid_o=1, inst_o=0x00000013 in that cycle. Without it: the same stimulus gives inst_valid_o=1 one cycle later.
